// File: rtl/scanchain_reader.sv
// Scan-chain read-back engine: shifts an address into the chip, runs one capture period, then
// shifts the addressed word out of scan_out. Define SCANCHAIN_READER_PARITY_EN for a trailing even-parity bit.
module scanchain_reader #(
  parameter int CLOCK_FREQ          = 100_000_000,
  parameter int CLOCKS_PER_SCAN_CLK = 100_000,
  parameter int ADDR_BITS           = 12,
  parameter int PAYLOAD_BITS        = 160
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    read_valid,
  output logic                    read_ready,
  input  logic [ADDR_BITS-1:0]    read_addr,
  output logic                    read_data_valid,
  input  logic                    read_data_ready,
  output logic [PAYLOAD_BITS-1:0] read_data,
  output logic                    read_err,
  output logic                    scan_clk,
  output logic                    scan_en,
  output logic                    scan_in,
  input  logic                    scan_out
);

`ifdef SCANCHAIN_READER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif
  localparam int DATA_BITS = PAYLOAD_BITS + PARITY_BITS;
  localparam int MAX_BITS  = (ADDR_BITS > PAYLOAD_BITS + 1) ? ADDR_BITS : PAYLOAD_BITS + 1;
  localparam int BIT_W     = $clog2(MAX_BITS) + 1;
  localparam int CYC_W     = $clog2(CLOCKS_PER_SCAN_CLK);

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CLOCKS_PER_SCAN_CLK - 1);
  localparam logic [CYC_W-1:0] CYC_HALF  = CYC_W'(CLOCKS_PER_SCAN_CLK / 2);
  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

  if (CLOCKS_PER_SCAN_CLK < 8 || (CLOCKS_PER_SCAN_CLK % 2) != 0 || CLOCK_FREQ <= 0) begin : g_bad_params
    $error("scanchain_reader: CLOCKS_PER_SCAN_CLK must be even and at least 8");
  end

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CAPTURE, S_DATA, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [CYC_W-1:0]        cyc_q, cyc_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [DATA_BITS-1:0]    shift_q, shift_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic [1:0]              sync_q, sync_d;
  logic                    scan_clk_q, scan_clk_d;
  logic                    scan_en_q, scan_en_d;
  logic                    scan_in_q, scan_in_d;
  logic                    period_end;
  logic                    active_d;
`ifdef SCANCHAIN_READER_PARITY_EN
  logic                    err_q, err_d;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    data_d     = data_q;
`ifdef SCANCHAIN_READER_PARITY_EN
    err_d      = err_q;
`endif
    sync_d     = {sync_q[0], scan_out};
    period_end = (cyc_q == CYC_LAST);

    if (state_q inside {S_ADDR, S_CAPTURE, S_DATA}) begin
      cyc_d = period_end ? '0 : cyc_q + CYC_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (read_valid) begin
          state_d = S_ADDR;
          addr_d  = read_addr;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
      S_ADDR: begin
        if (period_end) begin
          addr_d = {addr_q[ADDR_BITS-2:0], 1'b0};
          if (bit_q == ADDR_LAST) begin
            state_d = S_CAPTURE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_CAPTURE: begin
        if (period_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        // Sample on the last cycle of the high half, just before scan_clk falls and the chip shifts.
        if (period_end) begin
          shift_d = {shift_q[DATA_BITS-2:0], sync_q[1]};
          if (bit_q == DATA_LAST) begin
            state_d = S_DONE;
            bit_d   = '0;
            data_d  = shift_d[DATA_BITS-1 -: PAYLOAD_BITS];
`ifdef SCANCHAIN_READER_PARITY_EN
            err_d   = ^shift_d;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (read_data_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pin values are derived from the next state so they leave the flops glitch-free.
    active_d   = state_d inside {S_ADDR, S_CAPTURE, S_DATA};
    scan_clk_d = active_d && (cyc_d >= CYC_HALF);
    scan_en_d  = (state_d == S_ADDR) || (state_d == S_DATA);
    scan_in_d  = (state_d == S_ADDR) && addr_d[ADDR_BITS-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      addr_q     <= '0;
      // NOTE: the wide shift/data registers are reset as well; read_data must read 0 after reset.
      shift_q    <= '0;
      data_q     <= '0;
      sync_q     <= '0;
      scan_clk_q <= 1'b0;
      scan_en_q  <= 1'b0;
      scan_in_q  <= 1'b0;
`ifdef SCANCHAIN_READER_PARITY_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      sync_q     <= sync_d;
      scan_clk_q <= scan_clk_d;
      scan_en_q  <= scan_en_d;
      scan_in_q  <= scan_in_d;
`ifdef SCANCHAIN_READER_PARITY_EN
      err_q      <= err_d;
`endif
    end
  end

  assign read_ready      = (state_q == S_IDLE);
  assign read_data_valid = (state_q == S_DONE);
  assign read_data       = data_q;
  assign scan_clk        = scan_clk_q;
  assign scan_en         = scan_en_q;
  assign scan_in         = scan_in_q;
`ifdef SCANCHAIN_READER_PARITY_EN
  assign read_err        = err_q;
`else
  assign read_err        = 1'b0;
`endif

endmodule

// File: tb/tb_scanchain_reader.sv
// Self-checking bench for scanchain_reader: table of reads (directed + random) against a
// behavioural chip model, plus hand-written reset and handshake sequences.
module tb_scanchain_reader;
  localparam int CPS = 8;
  localparam int AB  = 12;
  localparam int PB  = 160;
`ifdef SCANCHAIN_READER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int CW   = PB + PAR;
  localparam int NVEC = 12;

  typedef logic [PB-1:0] word_t;

  typedef struct {
    logic [AB-1:0] addr;
    word_t         payload;
    logic          parity;
    bit            pulse_busy;
    bit            hold;
    bit            b2b;
    word_t         exp_data;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  logic          clk             = 1'b0;
  logic          n_reset         = 1'b0;
  logic          read_valid      = 1'b0;
  logic          read_data_ready = 1'b0;
  logic [AB-1:0] read_addr       = '0;
  logic          read_ready, read_data_valid, read_err;
  logic          scan_clk, scan_en, scan_in, scan_out;
  word_t         read_data;

  scanchain_reader #(
    .CLOCK_FREQ(100_000_000),
    .CLOCKS_PER_SCAN_CLK(CPS),
    .ADDR_BITS(AB),
    .PAYLOAD_BITS(PB)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .read_valid(read_valid),
    .read_ready(read_ready),
    .read_addr(read_addr),
    .read_data_valid(read_data_valid),
    .read_data_ready(read_data_ready),
    .read_data(read_data),
    .read_err(read_err),
    .scan_clk(scan_clk),
    .scan_en(scan_en),
    .scan_in(scan_in),
    .scan_out(scan_out)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Chip model: shifts the address in on scan_clk rise, loads the word on the capture rise
  // (scan_en=0), then presents one bit per period, advancing on each scan_clk fall.
  logic [CW-1:0] chip_load   = '0;
  logic [CW-1:0] chip_sr     = '0;
  logic [AB-1:0] chip_addr   = '0;
  logic [AB-1:0] cap_addr    = '0;
  logic          cap_scan_in = 1'b0;
  logic          captured    = 1'b0;
  logic          pending     = 1'b0;
  logic          prev_clk    = 1'b0;
  logic          prev_en     = 1'b0;
  assign scan_out = chip_sr[CW-1];

  always @(scan_clk or scan_en) begin
    if (scan_clk === 1'b1 && prev_clk === 1'b0) begin
      if (scan_en === 1'b1) begin
        if (!captured) chip_addr = {chip_addr[AB-2:0], scan_in};
        else pending = 1'b1;
      end else begin
        chip_sr     = chip_load;
        captured    = 1'b1;
        cap_addr    = chip_addr;
        cap_scan_in = scan_in;
      end
    end
    if (scan_clk === 1'b0 && prev_clk === 1'b1 && pending) begin
      chip_sr = chip_sr << 1;
      pending = 1'b0;
    end
    if (scan_en === 1'b0 && prev_en === 1'b1) begin
      captured = 1'b0;
      pending  = 1'b0;
    end
    prev_clk = scan_clk;
    prev_en  = scan_en;
  end

  // Pin monitor: half-periods of CPS/2 cycles, scan_in/scan_en steady while scan_clk is high.
  int   mon_stable_viol = 0;
  int   mon_timing_viol = 0;
  int   hi_run = 0;
  int   lo_run = 0;
  logic m_clk = 1'b0, m_in = 1'b0, m_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (n_reset !== 1'b1) begin
      hi_run = 0;
      lo_run = 0;
    end else if (scan_clk === 1'b1) begin
      if (scan_in !== m_in || scan_en !== m_en) mon_stable_viol++;
      if (m_clk === 1'b0 && lo_run != 0 && lo_run != CPS / 2) mon_timing_viol++;
      hi_run++;
      lo_run = 0;
    end else begin
      if (m_clk === 1'b1 && hi_run != CPS / 2) mon_timing_viol++;
      hi_run = 0;
      if (!read_ready && !read_data_valid) lo_run++;
      else lo_run = 0;
    end
    m_clk = scan_clk;
    m_in  = scan_in;
    m_en  = scan_en;
  end

  // Reference model: the chip returns the payload unchanged; error is the even-parity check.
  function automatic vec_t mk(input logic [AB-1:0] a, input word_t p, input logic par,
                              input bit pulse, input bit hold, input bit b2b);
    vec_t v;
    v.addr       = a;
    v.payload    = p;
    v.parity     = par;
    v.pulse_busy = pulse;
    v.hold       = hold;
    v.b2b        = b2b;
    v.exp_data   = p;
    v.exp_err    = (PAR == 1) ? (^p ^ par) : 1'b0;
    v.exp_lat    = (AB + 1 + PB + PAR) * CPS;
    return v;
  endfunction

  task automatic accept_read(input logic [AB-1:0] addr, output int acc, output int waited);
    @(negedge clk);
    read_valid = 1'b1;
    read_addr  = addr;
    waited     = 0;
    while (!read_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait_bound", word_t'(waited >= 200), word_t'(0));
    @(posedge clk);
    #1;
    acc = cyc_cnt;
    check("accept_ready_drop", word_t'(read_ready), word_t'(0));
    read_valid = 1'b0;
    read_addr  = AB'($urandom);
  endtask

  task automatic run_vec(input vec_t v, input word_t prev);
    int          acc, waited, lat, bad;
    word_t       held;
    logic [PB:0] ld;
    ld        = {v.payload, v.parity};
    chip_load = (PAR == 1) ? CW'(ld) : CW'(ld >> 1);
    if (!v.b2b) repeat (3) @(posedge clk);
    accept_read(v.addr, acc, waited);
    if (v.b2b) check("b2b_first_cycle", word_t'(waited), word_t'(0));
    lat = -1;
    while (lat < 0 && (cyc_cnt - acc) < 3000) begin
      @(posedge clk);
      #1;
      if (read_data_valid) lat = cyc_cnt - acc;
      else begin
        if (v.pulse_busy && cyc_cnt - acc == 20) begin
          read_valid      = 1'b1;
          read_addr       = '1;
          read_data_ready = 1'b1;
        end
        if (v.pulse_busy && cyc_cnt - acc == 23)
          check("busy_not_ready", word_t'(read_ready), word_t'(0));
        if (cyc_cnt - acc == 26) begin
          read_valid      = 1'b0;
          read_data_ready = 1'b0;
        end
        if (cyc_cnt - acc == 200) check("data_held_during_read", read_data, prev);
      end
    end
    check("latency", word_t'(lat), word_t'(v.exp_lat));
    check("read_data", read_data, v.exp_data);
    check("read_err", word_t'(read_err), word_t'(v.exp_err));
    check("chip_addr", word_t'(cap_addr), word_t'(v.addr));
    check("capture_scan_in", word_t'(cap_scan_in), word_t'(0));
    check("done_pins_idle", word_t'({scan_clk, scan_en, read_ready}), word_t'(0));
    if (v.hold) begin
      held = read_data;
      bad  = 0;
      repeat (50) begin
        @(posedge clk);
        #1;
        if (!read_data_valid || read_ready || scan_clk || scan_en || read_data !== held) bad++;
      end
      check("backpressure_stable", word_t'(bad), word_t'(0));
    end
    read_data_ready = 1'b1;
    @(posedge clk);
    #1;
    read_data_ready = 1'b0;
    check("consume_to_idle", word_t'({read_data_valid, read_ready}), word_t'(2'b01));
  endtask

  vec_t vecs[NVEC];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    acc, waited, bad;
    word_t prev;

    vecs[0] = mk(12'hA5C, 160'h0123456789ABCDEF0123456789ABCDEF89ABCDEF, 1'b1, 1'b0, 1'b1, 1'b0);
    vecs[1] = mk(12'h3C3, '1, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[2] = mk(12'h000, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[3] = mk(12'h555, {40{4'hA}}, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[4] = mk(12'h7E1, 160'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[5] = mk(12'h7E1, 160'h1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 6; i < NVEC; i++)
      vecs[i] = mk(AB'($urandom), {$urandom, $urandom, $urandom, $urandom, $urandom},
                   1'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));

    // Reset with a pending request: nothing may start.
    n_reset    = 1'b0;
    read_valid = 1'b1;
    read_addr  = 12'h123;
    repeat (5) @(posedge clk);
    #1;
    check("reset_pins", word_t'({scan_clk, scan_en, scan_in, read_data_valid, read_ready, read_err}),
          word_t'(6'b000010));
    check("reset_data", read_data, '0);
    read_valid = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_pins", word_t'({scan_clk, scan_en, scan_in, read_data_valid, read_ready, read_err}),
          word_t'(6'b000010));

    // Abort mid-DATA, during a high half of scan_clk.
    chip_load = CW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    accept_read(12'h2B7, acc, waited);
    repeat (133) @(posedge clk);
    #1;
    check("mid_data_active", word_t'({scan_clk, scan_en}), word_t'(2'b11));
    #1;
    n_reset = 1'b0;
    #1;
    check("async_abort_pins", word_t'({scan_clk, scan_en, read_data_valid}), word_t'(0));
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    bad = 0;
    repeat (1500) begin
      @(posedge clk);
      #1;
      if (read_data_valid !== 1'b0 || read_ready !== 1'b1) bad++;
    end
    check("abort_no_valid", word_t'(bad), word_t'(0));
    check("abort_data_cleared", read_data, '0);

    prev = '0;
    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], prev);
      prev = vecs[i].exp_data;
    end

    repeat (20) @(posedge clk);
    #1;
    check("final_data_held", read_data, prev);
    check("scan_in_stable_while_high", word_t'(mon_stable_viol), word_t'(0));
    check("scan_clk_half_periods", word_t'(mon_timing_viol), word_t'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scanchain_reader.md
Name: scanchain_reader

Overview:
- Read-back counterpart to the scan-chain writer. Takes an address from the host-side client over a valid/ready handshake.
- Shifts the address into the chip, pulses a capture cycle, then shifts PAYLOAD_BITS of read data out of the chip's SCAN_OUT pin.
- Presents the assembled word to the host-side client over a second valid/ready handshake.
- Sits beside scanchain_writer in the FPGA top and shares the chip's scan pins through an external mux; the mux is out of scope.

Parameters:
- CLOCK_FREQ, 100_000_000, FPGA clock frequency in Hz (informational).
- CLOCKS_PER_SCAN_CLK, 100_000, clk cycles per scan_clk period. Must be even and at least 8.
- ADDR_BITS, 12, address width shifted into the chip.
- PAYLOAD_BITS, 160, read data width shifted out of the chip.

Ports:
- clk  in  1  FPGA clock.
- n_reset  in  1  asynchronous, active-low reset.
- read_valid  in  1  host requests a read.
- read_ready  out  1  block can accept a request.
- read_addr  in  ADDR_BITS  register address; sampled on accept.
- read_data_valid  out  1  read_data holds a completed word.
- read_data_ready  in  1  host consumes read_data.
- read_data  out  PAYLOAD_BITS  captured word; MSB is the first bit received.
- read_err  out  1  parity error flag for the current read_data (see Optional Feature).
- scan_clk  out  1  scan clock to the chip.
- scan_en  out  1  scan enable to the chip.
- scan_in  out  1  serial address to the chip.
- scan_out  in  1  serial data from the chip; asynchronous to clk.

Behaviour:
- Reset (n_reset=0, asynchronous):
  - FSM goes to IDLE.
  - scan_clk=0, scan_en=0, scan_in=0, read_data_valid=0, read_err=0, read_data=0, all counters 0.
  - A reset mid-operation aborts the read and discards partial data.
- Synchronizer: scan_out passes through a 2-flop synchronizer before use.
- Scan clock generation: each scan period is HALF=CLOCKS_PER_SCAN_CLK/2 cycles with scan_clk=0, then HALF cycles with scan_clk=1.
  - scan_in and scan_en change only on the cycle scan_clk falls, or at period start.
  - Outputs are registered; no glitches.
- read_ready = (state==IDLE). Its value is 1 after reset.
- FSM states: IDLE, ADDR, CAPTURE, DATA, DONE.
  - IDLE: on read_valid && read_ready, latch read_addr into the shift register and go to ADDR in the next cycle.
  - ADDR: scan_en=1; scan_in = address bit, MSB first, held for one full scan period per bit. Runs for ADDR_BITS periods, then goes to CAPTURE.
  - CAPTURE: one scan period with scan_en=0 and scan_in=0; the chip loads the addressed register into its output shifter. Then goes to DATA.
  - DATA: scan_en=1, scan_in=0. Runs for PAYLOAD_BITS periods (PAYLOAD_BITS+1 with parity enabled).
    - On the last clk cycle of each high half, the synchronized scan_out is shifted into the LSB of the data register, so earlier bits move toward the MSB.
    - After the final period ends, scan_en=0 and the FSM goes to DONE.
  - DONE: read_data_valid=1; read_data and read_err are held stable. On read_data_ready, go to IDLE next cycle, with read_data_valid=0 and read_ready=1 in that cycle.
- Latency: read_data_valid rises exactly (ADDR_BITS+1+PAYLOAD_BITS)*CLOCKS_PER_SCAN_CLK cycles after the accept edge (plus CLOCKS_PER_SCAN_CLK if parity is enabled).
- Handshake rules:
  - read_valid while busy is ignored; the host must hold it until read_ready.
  - read_addr changes after accept have no effect.
  - read_data_ready outside DONE is ignored.
  - read_data keeps its last value until the next completed read overwrites it.
- Counters:
  - Bit counter is clog2(max(ADDR_BITS, PAYLOAD_BITS+1))+1 bits wide.
  - Cycle counter is clog2(CLOCKS_PER_SCAN_CLK) bits wide.
  - Both reset to 0 at every phase change.

Optional Feature:
- Macro: SCANCHAIN_READER_PARITY_EN.
- Defined:
  - DATA runs one extra scan period and samples a trailing parity bit from the chip.
  - read_err = XOR of the PAYLOAD_BITS data bits and the parity bit; the chip sends even parity, so read_err=1 flags a mismatch.
  - read_err is valid together with read_data_valid.
- Undefined: no extra period; read_err is tied to 0.

Test Plan:
1. Reset idle check. Apply n_reset=0 with read_valid=1, then release it → all scan outputs 0, read_ready=1, read_data_valid=0. Assert n_reset=0 mid-DATA → scan_clk and scan_en drop to 0 in the same cycle, and read_data_valid stays 0 after release.
2. Basic read (CLOCKS_PER_SCAN_CLK=8, ADDR_BITS=12, PAYLOAD_BITS=160, parity off). read_addr=12'hA5C, chip model returns 160'h0123…CDEF →
   - scan_in carries 101001011100 MSB first, one bit per 8-cycle period.
   - A capture period follows with scan_en=0.
   - read_data_valid rises exactly 1384 cycles after accept, with read_data=160'h0123…CDEF.
3. Backpressure: hold read_data_ready=0 for 50 cycles → read_data_valid stays 1, read_data stays stable, read_ready stays 0, scan_clk stays 0. Then raise read_data_ready → IDLE next cycle.
4. Ignored requests: pulse read_valid during ADDR with read_addr=12'hFFF → no second read starts and the current read is unaffected. Issue a back-to-back read right after DONE → it is accepted on the first cycle read_ready=1.
5. Data extremes: chip returns all-ones, then all-zeros, then alternating 1010… → read_data matches each exactly, and no bit shift is seen given the 2-cycle synchronizer delay.
6. Parity (SCANCHAIN_READER_PARITY_EN defined, pattern 160'h1, which has odd weight):
   - Parity bit 1 → read_err=0, and latency is 1392 cycles.
   - Parity bit 0 → read_err=1.
